// File: rtl/inst_fetch_queue.sv
// Instruction fetch front-end: credit-limited request issue to instruction memory and an
// in-order {pc, instruction} queue to the core. Optional stall counter under IFQ_PERF_EN.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
`ifdef IFQ_PERF_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [31:0]   fetch_pc_q;
    logic [31:0]   rsp_pc_q;
    logic [CW-1:0] occ_q;
    logic [CW-1:0] outst_q;
    logic [CW-1:0] drop_q;
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [31:0]   mem_data [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];

    logic        req_fire;
    logic        rsp_fire;
    logic        keep;
    logic        deq;
    logic [31:0] target_pc;
    logic        unused_redirect_lsb;

    assign target_pc           = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Queue entries plus outstanding requests never exceed DEPTH, so responses cannot overflow.
    assign imem_req_valid = rst_n && !redirect_valid
                            && ((int'(occ_q) + int'(outst_q)) < int'(DEPTH));
    assign imem_req_addr  = rst_n ? fetch_pc_q : RESET_PC;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fire = imem_rsp_valid && (outst_q != '0);
    assign keep     = rsp_fire && (drop_q == '0);

    assign inst_valid = rst_n && (occ_q != '0);
    assign inst_data  = rst_n ? mem_data[head_q] : 32'h0;
    assign inst_pc    = rst_n ? mem_pc[head_q] : RESET_PC;
    assign deq        = inst_valid && inst_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            occ_q      <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else if (redirect_valid) begin
            fetch_pc_q <= target_pc;
            rsp_pc_q   <= target_pc;
            occ_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            outst_q    <= outst_q - (rsp_fire ? ONE : '0);
            drop_q     <= outst_q - (rsp_fire ? ONE : '0);
        end else begin
            if (req_fire) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            outst_q <= outst_q + (req_fire ? ONE : '0) - (rsp_fire ? ONE : '0);
            if (rsp_fire && (drop_q != '0)) begin
                drop_q <= drop_q - ONE;
            end
            if (keep) begin
                rsp_pc_q <= rsp_pc_q + 32'd4;
                tail_q   <= tail_q + 1'b1;
            end
            if (deq) begin
                head_q <= head_q + 1'b1;
            end
            case ({keep, deq})
                2'b10:   occ_q <= occ_q + ONE;
                2'b01:   occ_q <= occ_q - ONE;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (rst_n && !redirect_valid && keep) begin
            mem_data[tail_q] <= imem_rsp_data;
            mem_pc[tail_q]   <= rsp_pc_q;
        end
    end

`ifdef IFQ_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= 32'h0;
        end else if (inst_ready && !inst_valid && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: in-order memory model with programmable latency,
// expected {pc, word} queue filled by directed phases and drained by an independent monitor.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef IFQ_PERF_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
`ifdef IFQ_PERF_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_pop    = 0;
    int n_acc    = 0;
    int lat      = 1;
    int mem_cyc  = 0;
    logic [31:0] exp_pc_q [$];
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {pc[23:0], 8'h13};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_from(input logic [31:0] start, input int n);
        logic [31:0] pc;
        exp_pc_q.delete();
        pc = start;
        for (int i = 0; i < n; i++) begin
            exp_pc_q.push_back(pc);
            pc = pc + 32'd4;
        end
    endtask

    // In-order memory: a word accepted in cycle c is presented in cycle c + lat.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                pend_addr.delete();
                pend_due.delete();
                imem_rsp_valid = 1'b0;
            end else begin
                if (pend_addr.size() > 0 && pend_due[0] <= mem_cyc) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = word_of(pend_addr[0]);
                    pend_addr.delete(0);
                    pend_due.delete(0);
                end else begin
                    imem_rsp_valid = 1'b0;
                end
                if (imem_req_valid && imem_req_ready) begin
                    pend_addr.push_back(imem_req_addr);
                    pend_due.push_back(mem_cyc + lat);
                    n_acc++;
                end
            end
            mem_cyc++;
        end
    end

    // Monitor: every delivered instruction must be the next expected one.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
                n_pop++;
                if (exp_pc_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL pop_unexpected: got pc %h, nothing expected", inst_pc);
                end else begin
                    e = exp_pc_q.pop_front();
                    check("pop_pc", inst_pc, e);
                    check("pop_data", inst_data, word_of(e));
                end
            end
        end
    end

    initial begin
        int p;
        int acc_base;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;

        // Reset outputs
        repeat (3) tick();
        #3;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_req_addr", imem_req_addr, 32'h0);

        // Streaming from reset, 1-cycle memory
        tick(); rst_n = 1'b1; inst_ready = 1'b1;
        #3;
        expect_from(32'h0, 24);
        p = n_pop;
        check("first_req_valid", imem_req_valid, 1);
        check("first_req_addr", imem_req_addr, 32'h0);
        check("c0_inst_valid", inst_valid, 0);
        tick(); #3;
        check("c1_inst_valid", inst_valid, 0);
        tick(); #3;
        check("c2_inst_valid", inst_valid, 1);
        check("c2_inst_pc", inst_pc, 32'h0);
        check("c2_inst_data", inst_data, 32'h0000_0013);
        repeat (8) tick();
        #3;
        check("stream_pops", n_pop - p, 9);

        // Back-pressure: fill to DEPTH, then drain
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h200; inst_ready = 1'b0;
        #3;
        check("redir_no_req", imem_req_valid, 0);
        expect_from(32'h200, 24);
        acc_base = n_acc;
        tick(); redirect_valid = 1'b0;
        #3;
        check("redir_next_valid", imem_req_valid, 1);
        check("redir_next_addr", imem_req_addr, 32'h200);
        repeat (7) tick();
        #3;
        check("full_req_valid", imem_req_valid, 0);
        check("full_accepts", n_acc - acc_base, 4);
        check("full_head_pc", inst_pc, 32'h200);
        tick(); inst_ready = 1'b1;
        #3;
        check("drain_credit_late", imem_req_valid, 0);
        tick(); #3;
        check("resume_req_valid", imem_req_valid, 1);
        check("resume_req_addr", imem_req_addr, 32'h210);

        // 3-cycle memory, redirect with requests in flight
        lat = 3;
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h400;
        #3;
        expect_from(32'h400, 24);
        tick(); redirect_valid = 1'b0;
        repeat (6) tick();
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h103;
        #3;
        check("redir2_no_req", imem_req_valid, 0);
        expect_from(32'h100, 24);
        tick(); redirect_valid = 1'b0;
        #3;
        check("redir2_addr", imem_req_addr, 32'h100);
        check("redir2_valid", imem_req_valid, 1);
        p = n_pop;
        repeat (3) begin
            tick(); #3;
            check("lat3_empty", inst_valid, 0);
        end
        tick(); #3;
        check("lat3_valid", inst_valid, 1);
        check("lat3_pc", inst_pc, 32'h100);
        check("lat3_pops", n_pop - p, 1);

        // Redirect coinciding with a response and a ready core, occupancy 2
        tick(); inst_ready = 1'b0;
        repeat (8) tick();
        lat = 2;
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h300;
        #3;
        expect_from(32'h300, 24);
        tick(); redirect_valid = 1'b0;
        tick(); tick(); tick();
        #3;
        check("occ_head_pc", inst_pc, 32'h300);
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h500; inst_ready = 1'b1;
        #3;
        check("coinc_no_req", imem_req_valid, 0);
        p = n_pop;
        expect_from(32'h500, 24);
        tick(); redirect_valid = 1'b0;
        #3;
        check("coinc_next_addr", imem_req_addr, 32'h500);
        tick(); tick(); tick();
        #3;
        check("coinc_pops", n_pop - p, 1);
        check("coinc_pc", inst_pc, 32'h500);

        // PC wrap-around
        lat = 1;
        tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF9;
        #3;
        expect_from(32'hFFFF_FFF8, 24);
        tick(); redirect_valid = 1'b0;
        #3;
        check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFF8);
        tick(); tick(); #3;
        check("wrap_pc0", inst_pc, 32'hFFFF_FFF8);
        tick(); #3;
        check("wrap_pc1", inst_pc, 32'hFFFF_FFFC);
        tick(); #3;
        check("wrap_pc2", inst_pc, 32'h0000_0000);

        // Mid-operation reset, then 3-cycle memory from reset
        tick(); rst_n = 1'b0;
        #3;
        check("mrst_req_valid", imem_req_valid, 0);
        check("mrst_inst_valid", inst_valid, 0);
        check("mrst_inst_pc", inst_pc, 32'h0);
        check("mrst_inst_data", inst_data, 32'h0);
        tick();
        tick(); rst_n = 1'b1; lat = 3;
        #3;
        expect_from(32'h0, 24);
        check("mrst_first_addr", imem_req_addr, 32'h0);
        check("mrst_first_valid", imem_req_valid, 1);
        repeat (3) begin
            tick(); #3;
            check("mrst_empty", inst_valid, 0);
        end
        tick(); #3;
        check("mrst_valid", inst_valid, 1);
        check("mrst_pc", inst_pc, 32'h0);
`ifdef IFQ_PERF_EN
        check("stall_cycles", stall_cycles, 32'd4);
`endif
        repeat (6) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
